nfu2_reuse_accum: RTL
=====================

Name: nfu2_reuse_accum

Overview:
- Parametrised NFU-2 stage with multiplier-output reuse: Tn output lanes, each summing its Tn fresh NFU-1 products, up to IN_LIMIT products replayed from a per-lane reuse buffer, and the NBout partial sum.
- Replaces the fixed-size combinational select/add pair with a 2-stage pipeline that has valid/stall control, per-entry buffer valid tracking, and miss reporting.
- Sits between the NFU-1 multiplier array and the NFU-3 / NBout register.

Parameters:
- BIT_WIDTH, 16, signed two's-complement width of products, partial sums and outputs.
- Tn, 16, number of lanes and number of products per lane.
- IN_LIMIT, 3, number of reuse read slots per lane per cycle.
- ADDR_SIZE, 2, reuse buffer address width; depth is NUM_BUFFERS = 1<<ADDR_SIZE.
- SEL_WIDTH, 4, width of the write-select index into a lane's Tn products; 1<<SEL_WIDTH >= Tn.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- i_valid, input, 1, input beat valid.
- i_stall, input, 1, downstream stall; freezes the pipeline.
- i_nfu1, input, Tn*Tn*BIT_WIDTH, products. Lane j, product k is at [(j*Tn+k)*BIT_WIDTH +: BIT_WIDTH].
- i_partial_sum, input, Tn*BIT_WIDTH, per-lane partial sum.
- i_rd_en, input, Tn*IN_LIMIT, per-lane, per-slot reuse enable.
- i_rd_addr, input, Tn*IN_LIMIT*ADDR_SIZE, per-slot reuse buffer address.
- i_wr_en, input, Tn, per-lane buffer write enable.
- i_wr_addr, input, Tn*ADDR_SIZE, per-lane write address.
- i_wr_sel, input, Tn*SEL_WIDTH, index of the lane product to store.
- i_buf_clear, input, 1, invalidate all buffer entries.
- o_valid, output, 1, output beat valid.
- o_nfu2B, output, Tn*BIT_WIDTH, per-lane sums.
- o_miss, output, Tn, lane read at least one invalid entry in this beat.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: o_valid=0, o_nfu2B=0, o_miss=0, all pipeline registers 0, all buffer valid bits 0. Buffer data is not reset.
- Advance condition: adv = ~i_stall. When i_stall=1, every pipeline register, o_* output and buffer write holds. Inputs presented during a stall are ignored.
- Stage 1 (at posedge with adv):
  - Register s1_valid = i_valid.
  - Per lane, register the sum of its Tn fresh products and the partial sum.
  - Per lane, register IN_LIMIT reuse operands. Operand = buf[addr] when i_rd_en=1 and the entry is valid; otherwise 0.
  - Register the miss flag = OR over slots of (i_rd_en & ~entry_valid).
- Stage 2 (at posedge with adv):
  - o_valid = s1_valid.
  - o_nfu2B lane = clamp(fresh_sum + reuse operands).
  - o_miss = registered miss flag.
- Latency: exactly 2 advancing cycles from input to o_valid. Throughput: one beat per cycle.
- Accumulator width: internal sums use BIT_WIDTH + clog2(Tn+IN_LIMIT+1) bits, sign-extended. There is no overflow before the final clamp.
- Buffer write: occurs only when i_valid & adv & i_wr_en[j]. It writes product i_wr_sel[j] of lane j into buf[j][i_wr_addr[j]] and sets that entry's valid bit. If i_wr_sel >= Tn, no write occurs.
- Read and write to the same address in the same cycle: the read returns the old contents and old valid bit (read-before-write). The new value is visible next beat.
- Beats with i_valid=0: reads are still evaluated, but o_valid=0 for that beat and no write occurs.
- i_buf_clear: clears all valid bits at the next posedge, regardless of i_stall. If a write coincides with a clear, the clear wins.
- Reset mid-operation: in-flight beats are discarded; o_valid=0 the cycle after rst.
- Unenabled read slots contribute 0 and never raise o_miss.

Optional Feature:
- Macro: NFU2_SATURATE_EN.
- Defined: the stage-2 clamp saturates to [-(2^(BIT_WIDTH-1)), 2^(BIT_WIDTH-1)-1].
- Undefined: the stage-2 clamp truncates to the low BIT_WIDTH bits (wrap-around).
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then i_valid=1, all products=1, partial_sum=5, no reuse: o_valid=1 two cycles later and every lane = 21 (Tn=16). Before that, o_valid=0.
- Beat 1: i_wr_en lane0=1, addr=2, sel=3, product[0][3]=100. Beat 2: lane0 rd_en slot0 at addr 2, fresh products=0, psum=0: lane0 = 100, o_miss[0]=0.
- Read of an unwritten entry, and read after i_buf_clear: operand 0 and o_miss set for that lane. Same-cycle write and read of addr 1: old value read; the next beat reads the new value.
- i_stall asserted for 3 cycles mid-stream (beats A, B in flight): outputs are held, no beat is lost or duplicated, and A, B emerge in order after release.
- All products 0x7FFF, psum 0x7FFF: with NFU2_SATURATE_EN the output is 0x7FFF; without it the output is the low 16 bits of 17*32767 = 0x7FEF. All products 0x8000, psum 0x8000 with NFU2_SATURATE_EN: output 0x8000.
- rst asserted while two beats are in flight: o_valid=0 the next cycle, the buffer valid bits are cleared, and subsequent reuse reads set o_miss.

Source files
------------

// File: rtl/nfu2_reuse_accum_if.sv
// ---------------------------------------------------------------------------
// nfu2_reuse_accum_if
// Bundles the beat handshake, product/partial-sum data, reuse-buffer control
// and result signals of the NFU-2 reuse accumulator.
//   master : drives i_* (NFU-1 side / controller), receives o_*
//   slave  : the accumulator itself, receives i_*, drives o_*
// Signals:
//   i_valid, i_stall           beat valid / downstream stall
//   i_nfu1, i_partial_sum      Tn*Tn products, Tn partial sums
//   i_rd_en, i_rd_addr         per-lane, per-slot reuse reads
//   i_wr_en, i_wr_addr, i_wr_sel  per-lane reuse buffer write
//   i_buf_clear                invalidate every buffer entry
//   o_valid, o_nfu2B, o_miss   result beat, per-lane sums, per-lane miss
// ---------------------------------------------------------------------------
interface nfu2_reuse_accum_if #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int IN_LIMIT  = 3,
    parameter int ADDR_SIZE = 2,
    parameter int SEL_WIDTH = 4
);
    logic                               i_valid;
    logic                               i_stall;
    logic [Tn*Tn*BIT_WIDTH-1:0]         i_nfu1;
    logic [Tn*BIT_WIDTH-1:0]            i_partial_sum;
    logic [Tn*IN_LIMIT-1:0]             i_rd_en;
    logic [Tn*IN_LIMIT*ADDR_SIZE-1:0]   i_rd_addr;
    logic [Tn-1:0]                      i_wr_en;
    logic [Tn*ADDR_SIZE-1:0]            i_wr_addr;
    logic [Tn*SEL_WIDTH-1:0]            i_wr_sel;
    logic                               i_buf_clear;
    logic                               o_valid;
    logic [Tn*BIT_WIDTH-1:0]            o_nfu2B;
    logic [Tn-1:0]                      o_miss;

    modport master (
        output i_valid, i_stall, i_nfu1, i_partial_sum, i_rd_en, i_rd_addr,
               i_wr_en, i_wr_addr, i_wr_sel, i_buf_clear,
        input  o_valid, o_nfu2B, o_miss
    );

    modport slave (
        input  i_valid, i_stall, i_nfu1, i_partial_sum, i_rd_en, i_rd_addr,
               i_wr_en, i_wr_addr, i_wr_sel, i_buf_clear,
        output o_valid, o_nfu2B, o_miss
    );
endinterface

// File: rtl/nfu2_reuse_accum.sv
// ---------------------------------------------------------------------------
// nfu2_reuse_accum
// NFU-2 adder stage with multiplier-output reuse. Each of Tn lanes adds its Tn
// fresh NFU-1 products, its partial sum and up to IN_LIMIT products replayed
// from a small per-lane reuse buffer. Two pipeline stages, both frozen by
// i_stall:
//   stage 1 : fresh sum + partial sum, reuse buffer reads, miss detection
//   stage 2 : add reuse operands, clamp to BIT_WIDTH, register outputs
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   nfu2_reuse_accum_if.slave (all data/handshake signals)
// Optional build macro NFU2_SATURATE_EN: when defined the final clamp
// saturates; otherwise the result wraps to the low BIT_WIDTH bits.
// ---------------------------------------------------------------------------
module nfu2_reuse_accum #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int IN_LIMIT  = 3,
    parameter int ADDR_SIZE = 2,
    parameter int SEL_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    nfu2_reuse_accum_if.slave bus
);
    localparam int NUM_BUFFERS = 1 << ADDR_SIZE;
    // Wide enough for Tn products + partial sum + IN_LIMIT operands, so the
    // only overflow handling needed is the final clamp.
    localparam int ACC_W = BIT_WIDTH + $clog2(Tn + IN_LIMIT + 1);

`ifdef NFU2_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    function automatic logic signed [ACC_W-1:0] sext(input logic [BIT_WIDTH-1:0] v);
        return {{(ACC_W-BIT_WIDTH){v[BIT_WIDTH-1]}}, v};
    endfunction

    logic adv;
    logic s1_valid_reg;
    logic valid_reg;

    assign adv         = ~bus.i_stall;
    assign bus.o_valid = valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else if (adv) begin
            s1_valid_reg <= bus.i_valid;
            valid_reg    <= s1_valid_reg;
        end
    end

    for (genvar gi = 0; gi < Tn; gi++) begin : g_lane
        logic signed [ACC_W-1:0]     fresh_sum_next;
        logic signed [ACC_W-1:0]     fresh_sum_reg;
        logic signed [BIT_WIDTH-1:0] operand_next [IN_LIMIT];
        logic signed [BIT_WIDTH-1:0] operand_reg  [IN_LIMIT];
        logic                        miss_next;
        logic                        miss_reg;
        logic signed [ACC_W-1:0]     total_next;
        logic [BIT_WIDTH-1:0]        clamp_next;
        logic [BIT_WIDTH-1:0]        out_sum_reg;
        logic                        out_miss_reg;

        // Reuse buffer: data is never reset, only the per-entry valid bits.
        logic [BIT_WIDTH-1:0]        buf_mem [NUM_BUFFERS];
        logic [NUM_BUFFERS-1:0]      buf_valid_reg;
        logic [ADDR_SIZE-1:0]        wr_addr;
        logic [SEL_WIDTH-1:0]        wr_sel;
        logic [BIT_WIDTH-1:0]        wr_data;
        logic                        wr_sel_hit;
        logic                        wr_do;

        assign wr_addr = bus.i_wr_addr[gi*ADDR_SIZE +: ADDR_SIZE];
        assign wr_sel  = bus.i_wr_sel[gi*SEL_WIDTH +: SEL_WIDTH];

        // Fresh products plus partial sum.
        always_comb begin
            fresh_sum_next = sext(bus.i_partial_sum[gi*BIT_WIDTH +: BIT_WIDTH]);
            for (int k = 0; k < Tn; k++) begin
                fresh_sum_next = fresh_sum_next
                               + sext(bus.i_nfu1[(gi*Tn+k)*BIT_WIDTH +: BIT_WIDTH]);
            end
        end

        // Reuse reads see the buffer as it was before this edge's write.
        always_comb begin
            miss_next = 1'b0;
            for (int s = 0; s < IN_LIMIT; s++) begin
                logic [ADDR_SIZE-1:0] ra;
                logic                 en;
                ra = bus.i_rd_addr[(gi*IN_LIMIT+s)*ADDR_SIZE +: ADDR_SIZE];
                en = bus.i_rd_en[gi*IN_LIMIT+s];
                operand_next[s] = '0;
                if (en && buf_valid_reg[ra]) begin
                    operand_next[s] = buf_mem[ra];
                end
                if (en && !buf_valid_reg[ra]) begin
                    miss_next = 1'b1;
                end
            end
        end

        // Select the product to store; a select index >= Tn matches nothing
        // and therefore suppresses the write.
        always_comb begin
            wr_sel_hit = 1'b0;
            wr_data    = '0;
            for (int k = 0; k < Tn; k++) begin
                if (wr_sel == SEL_WIDTH'(k)) begin
                    wr_sel_hit = 1'b1;
                    wr_data    = bus.i_nfu1[(gi*Tn+k)*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end

        assign wr_do = adv & bus.i_valid & bus.i_wr_en[gi] & wr_sel_hit;

        always_ff @(posedge clk) begin
            if (wr_do) begin
                buf_mem[wr_addr] <= wr_data;
            end
        end

        // Clear acts even while stalled and overrides a coincident write.
        always_ff @(posedge clk) begin
            if (rst || bus.i_buf_clear) begin
                buf_valid_reg <= '0;
            end else if (wr_do) begin
                buf_valid_reg[wr_addr] <= 1'b1;
            end
        end

        // Stage 1 registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                fresh_sum_reg <= '0;
                miss_reg      <= 1'b0;
                for (int s = 0; s < IN_LIMIT; s++) begin
                    operand_reg[s] <= '0;
                end
            end else if (adv) begin
                fresh_sum_reg <= fresh_sum_next;
                miss_reg      <= miss_next;
                for (int s = 0; s < IN_LIMIT; s++) begin
                    operand_reg[s] <= operand_next[s];
                end
            end
        end

        // Stage 2: add reuse operands and clamp.
        always_comb begin
            total_next = fresh_sum_reg;
            for (int s = 0; s < IN_LIMIT; s++) begin
                total_next = total_next + sext(operand_reg[s]);
            end
`ifdef NFU2_SATURATE_EN
            if (total_next > SAT_MAX) begin
                clamp_next = SAT_MAX[BIT_WIDTH-1:0];
            end else if (total_next < SAT_MIN) begin
                clamp_next = SAT_MIN[BIT_WIDTH-1:0];
            end else begin
                clamp_next = total_next[BIT_WIDTH-1:0];
            end
`else
            clamp_next = total_next[BIT_WIDTH-1:0];
`endif
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_sum_reg  <= '0;
                out_miss_reg <= 1'b0;
            end else if (adv) begin
                out_sum_reg  <= clamp_next;
                out_miss_reg <= miss_reg;
            end
        end

        assign bus.o_nfu2B[gi*BIT_WIDTH +: BIT_WIDTH] = out_sum_reg;
        assign bus.o_miss[gi]                         = out_miss_reg;
    end

endmodule
